// File: rtl/vm_pkg.sv
// vm_pkg: shared types for the VM vending front end.
// Coin encodings, coin values, collector states, default width.
package vm_pkg;

  localparam int CREDIT_W = 4;

  typedef enum logic [1:0] {
    COIN_1  = 2'b00,
    COIN_2  = 2'b01,
    COIN_5  = 2'b10,
    COIN_10 = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_PRESENT,
    S_REFUND
  } cc_state_t;

  function automatic logic [3:0] coin_value(
    input logic [1:0] ct
  );
    logic [3:0] v;
    unique case (ct)
      COIN_1:  v = 4'd1;
      COIN_2:  v = 4'd2;
      COIN_5:  v = 4'd5;
      COIN_10: v = 4'd10;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_collector_if.sv
// coin_collector_if: customer/VM side signals of coin_collector.
// master drives coin/sel/cancel/vend inputs; slave is the collector.
interface coin_collector_if #(
  parameter int W = vm_pkg::CREDIT_W
) ();

  logic         coin_valid;
  logic [1:0]   coin_type;
  logic         sel_req;
  logic         cancel;
  logic         vend_done;
  logic         vend_fail;
  logic [W-1:0] vm_balance;
  logic [W-1:0] coins;
  logic         credit_valid;
  logic         coin_reject;
  logic         refund_valid;
  logic [W-1:0] refund_amt;
  logic         busy;

  modport master (
    output coin_valid, coin_type, sel_req,
    output cancel, vend_done, vend_fail,
    output vm_balance,
    input  coins, credit_valid, coin_reject,
    input  refund_valid, refund_amt, busy
  );

  modport slave (
    input  coin_valid, coin_type, sel_req,
    input  cancel, vend_done, vend_fail,
    input  vm_balance,
    output coins, credit_valid, coin_reject,
    output refund_valid, refund_amt, busy
  );

endinterface

// File: rtl/coin_collector_timeout.sv
// coin_timeout_ctr: idle-cycle counter with clear/enable.
// Ports: clk, rst, clr_i, en_i; expired_o high at TIMEOUT_CYC-1.
module coin_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate so a stalled FSM never wraps back to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != LAST)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/coin_collector.sv
// coin_collector: saturating coin credit front end for the VM core.
// Ports: clk, reset (async high), bus (coin_collector_if.slave).
module coin_collector #(
  parameter int CREDIT_W    = vm_pkg::CREDIT_W,
  parameter int MAX_CREDIT  = 15,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic             clk,
  input logic             reset,
  coin_collector_if.slave bus
);

  import vm_pkg::*;

  localparam logic [CREDIT_W:0] MAX_S =
    (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] MAX_C =
    CREDIT_W'(MAX_CREDIT);

  cc_state_t state_q, state_d;

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] amt_q, amt_d;
  logic [CREDIT_W-1:0] bal;
  logic [CREDIT_W:0]   sum;
  logic rej_q, rej_d;
  logic rfd_q, rfd_d;
  logic cv_q, busy_q;
  logic accept, tmr_clr, tmr_en, expired;

  // One extra bit so the overflow test never wraps.
  assign sum = {1'b0, credit_q}
             + (CREDIT_W+1)'(coin_value(bus.coin_type));
  assign accept = bus.coin_valid && (sum <= MAX_S);

  // A VM balance above the cap is clamped.
  assign bal = (bus.vm_balance > MAX_C) ?
               MAX_C : bus.vm_balance;

  coin_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmr (
    .clk      (clk),
    .rst      (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rej_d    = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmr_clr = 1'b1;
        rej_d   = bus.coin_valid && !accept;
        if (accept) begin
          credit_d = sum[CREDIT_W-1:0];
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (bus.cancel) begin
          rej_d   = bus.coin_valid;
          state_d = S_REFUND;
        end else if (bus.sel_req) begin
          rej_d   = bus.coin_valid;
          tmr_clr = 1'b1;
          state_d = S_PRESENT;
        end else if (accept) begin
          credit_d = sum[CREDIT_W-1:0];
          tmr_clr  = 1'b1;
        end else begin
          // A rejected coin is not activity.
          rej_d = bus.coin_valid;
          if (expired) state_d = S_REFUND;
          else         tmr_en  = 1'b1;
        end
      end
      S_PRESENT: begin
        rej_d = bus.coin_valid;
        if (bus.vend_done) begin
          credit_d = bal;
          tmr_clr  = 1'b1;
          state_d  = (bal == '0) ?
                     S_IDLE : S_COLLECT;
        end else if (bus.cancel) begin
          state_d = S_REFUND;
        end else if (bus.vend_fail) begin
          tmr_clr = 1'b1;
          state_d = S_COLLECT;
        end else if (expired) begin
          state_d = S_REFUND;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_REFUND: begin
        rej_d   = bus.coin_valid;
        tmr_clr = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    // Entering REFUND hands out the held credit.
    rfd_d = (state_d == S_REFUND);
    amt_d = rfd_d ? credit_q : '0;
    if (rfd_d) credit_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      amt_q    <= '0;
      rej_q    <= 1'b0;
      rfd_q    <= 1'b0;
      cv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      amt_q    <= amt_d;
      rej_q    <= rej_d;
      rfd_q    <= rfd_d;
      cv_q     <= (state_d == S_PRESENT);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign bus.coins        = credit_q;
  assign bus.credit_valid = cv_q;
  assign bus.coin_reject  = rej_q;
  assign bus.refund_valid = rfd_q;
  assign bus.refund_amt   = amt_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_coin_collector.sv
// tb_coin_collector: scoreboard bench for coin_collector.
// Model pushes expected outputs per cycle; popped after the edge.
module tb_coin_collector;

  localparam int W    = 4;
  localparam int MAXC = 15;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  coin_collector_if #(.W(W)) bus ();

  coin_collector #(
    .CREDIT_W   (W),
    .MAX_CREDIT (MAXC),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int coins;
    int cv;
    int rej;
    int rv;
    int amt;
    int busy;
  } exp_t;

  exp_t sbq[$];
  int checks   = 0;
  int failures = 0;

  // model: 0 idle, 1 collect, 2 present, 3 refund
  int ms = 0;
  int mc = 0;
  int mt = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d",
               tag, obs, exp);
    end
  endtask

  function automatic int cval(input int t);
    case (t)
      0:       return 1;
      1:       return 2;
      2:       return 5;
      default: return 10;
    endcase
  endfunction

  task automatic idle_in();
    bus.coin_valid = 0;
    bus.coin_type  = 0;
    bus.sel_req    = 0;
    bus.cancel     = 0;
    bus.vend_done  = 0;
    bus.vend_fail  = 0;
    bus.vm_balance = 0;
  endtask

  task automatic model_reset();
    ms = 0;
    mc = 0;
    mt = 0;
    sbq.delete();
  endtask

  task automatic step(
    input int cv, input int ct,
    input int sel, input int can,
    input int vd, input int vf,
    input int bal
  );
    exp_t e;
    int ns, nc, nt, rej, sum;
    bus.coin_valid = cv[0];
    bus.coin_type  = 2'(ct);
    bus.sel_req    = sel[0];
    bus.cancel     = can[0];
    bus.vend_done  = vd[0];
    bus.vend_fail  = vf[0];
    bus.vm_balance = 4'(bal);
    ns  = ms;
    nc  = mc;
    nt  = mt;
    rej = 0;
    sum = mc + cval(ct);
    case (ms)
      0: begin
        nt = 0;
        if (cv != 0) begin
          if (sum <= MAXC) begin
            nc = sum;
            ns = 1;
          end else rej = 1;
        end
      end
      1: begin
        if (can != 0) begin
          ns = 3; rej = cv;
        end else if (sel != 0) begin
          ns = 2; rej = cv; nt = 0;
        end else if (cv != 0 && sum <= MAXC) begin
          nc = sum; nt = 0;
        end else begin
          rej = cv;
          if (mt == TO - 1) ns = 3;
          else nt = mt + 1;
        end
      end
      2: begin
        rej = cv;
        if (vd != 0) begin
          nc = (bal > MAXC) ? MAXC : bal;
          ns = (nc == 0) ? 0 : 1;
          nt = 0;
        end else if (can != 0) ns = 3;
        else if (vf != 0) begin
          ns = 1; nt = 0;
        end else if (mt == TO - 1) ns = 3;
        else nt = mt + 1;
      end
      default: begin
        rej = cv; ns = 0; nt = 0;
      end
    endcase
    e.rv  = (ns == 3) ? 1 : 0;
    e.amt = (ns == 3) ? mc : 0;
    if (ns == 3) nc = 0;
    e.coins = nc;
    e.cv    = (ns == 2) ? 1 : 0;
    e.busy  = (ns != 0) ? 1 : 0;
    e.rej   = rej;
    sbq.push_back(e);
    ms = ns;
    mc = nc;
    mt = nt;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("coins", bus.coins, e.coins);
    chk("credit_valid", bus.credit_valid, e.cv);
    chk("coin_reject", bus.coin_reject, e.rej);
    chk("refund_valid", bus.refund_valid, e.rv);
    chk("refund_amt", bus.refund_amt, e.amt);
    chk("busy", bus.busy, e.busy);
    chk("excl_valid",
        bus.credit_valid & bus.refund_valid, 0);
    idle_in();
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_coins"}, bus.coins, 0);
    chk({t, "_cv"}, bus.credit_valid, 0);
    chk({t, "_rej"}, bus.coin_reject, 0);
    chk({t, "_rv"}, bus.refund_valid, 0);
    chk({t, "_amt"}, bus.refund_amt, 0);
    chk({t, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int pulses, amt;
    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // 1: 5 then 7
    step(1, 2, 0, 0, 0, 0, 0);
    chk("t1_coins5", bus.coins, 5);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("t1_coins7", bus.coins, 7);
    chk("t1_busy", bus.busy, 1);
    chk("t1_rej", bus.coin_reject, 0);

    // 2: 12 + 5 overflows
    step(1, 2, 0, 0, 0, 0, 0);
    chk("t2_coins12", bus.coins, 12);
    step(1, 2, 0, 0, 0, 0, 0);
    chk("t2_rej", bus.coin_reject, 1);
    chk("t2_hold", bus.coins, 12);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t2_rej_pulse", bus.coin_reject, 0);

    // 3: present, vend to zero
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t3_cv", bus.credit_valid, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t3_present_rej", bus.coin_reject, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t3_coins0", bus.coins, 0);
    chk("t3_idle", bus.busy, 0);

    // 4: vend_fail then cancel
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t4_coins3", bus.coins, 3);
    chk("t4_cv0", bus.credit_valid, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t4_rv", bus.refund_valid, 1);
    chk("t4_amt", bus.refund_amt, 3);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t4_refund_rej", bus.coin_reject, 1);
    chk("t4_idle", bus.busy, 0);

    // vend_done beats vend_fail, nonzero change
    step(1, 3, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 4);
    chk("vd_coins4", bus.coins, 4);
    chk("vd_busy", bus.busy, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("vd_amt", bus.refund_amt, 4);
    step(0, 0, 0, 0, 0, 0, 0);

    // 5: inactivity timeout
    step(1, 2, 0, 0, 0, 0, 0);
    pulses = 0;
    amt    = 0;
    for (int i = 0; i < TO + 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      if (bus.refund_valid === 1'b1) begin
        pulses++;
        amt = int'(bus.refund_amt);
      end
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_amt", amt, 5);

    // 6b: coin + cancel in COLLECT
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("t6_rej", bus.coin_reject, 1);
    chk("t6_amt", bus.refund_amt, 2);
    step(0, 0, 0, 0, 0, 0, 0);

    // 6a: async reset in PRESENT
    step(1, 3, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    chk_zero("arst");
    @(posedge clk);
    #1;
    chk("arst_rv", bus.refund_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 2) == 0) ? 1 : 0,
           $urandom_range(0, 3),
           ($urandom_range(0, 9) == 0) ? 1 : 0,
           ($urandom_range(0, 14) == 0) ? 1 : 0,
           ($urandom_range(0, 3) == 0) ? 1 : 0,
           ($urandom_range(0, 3) == 0) ? 1 : 0,
           $urandom_range(0, 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
